// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 8-bit datapath: steps each fetched instruction through
// FETCH/DECODE/EXEC/MEM/WB and issues the control word plus one-shot write/advance strobes.
module multicycle_sequencer #(
    parameter int unsigned CNT_W    = 8,
    parameter bit          USE_TICK = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TICK,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [7:0]       INSTR,
    output logic             IR_LOAD,
    output logic             PC_INC,
    output logic             PC_JMP,
    output logic             REG_WE,
    output logic             MEM_WE,
    output logic [7:0]       SIGNAL,
    output logic [2:0]       PHASE,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5
    } state_e;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpLw  = 2'b01;
    localparam logic [1:0] OpSw  = 2'b10;
    localparam logic [1:0] OpJ   = 2'b11;

    localparam logic [CNT_W-1:0] CntOne = 1;

    state_e           state_q;
    logic [7:0]       ir_q;
    logic             pending_q;
    logic [CNT_W-1:0] cnt_q;

    logic       adv;
    logic [1:0] op;
    logic       launch;
    logic       retire_cond;
    logic       retire;
    logic       launch_now;
    state_e     retire_next;
    logic       unused_ir;

    assign adv       = USE_TICK ? TICK : 1'b1;
    assign op        = ir_q[7:6];
    assign unused_ir = ^ir_q[5:0];
    assign launch    = RUN | pending_q;

    // The last phase of each opcode is where it retires.
    assign retire_cond = ((state_q == StExec) && (op == OpJ)) ||
                         ((state_q == StMem) && (op == OpSw)) ||
                         (state_q == StWb);
    assign retire      = retire_cond & adv;
    assign retire_next = launch ? StFetch : StIdle;
    assign launch_now  = adv & launch & ((state_q == StIdle) | retire_cond);

    assign IR_LOAD   = adv & (state_q == StFetch);
    assign REG_WE    = adv & (state_q == StWb);
    assign MEM_WE    = adv & (state_q == StMem) & (op == OpSw);
    assign PC_INC    = retire & (op != OpJ);
    assign PC_JMP    = retire & (op == OpJ);
    assign DONE      = retire;
    assign PHASE     = state_q;
    assign BUSY      = (state_q != StIdle);
    assign INSTR_CNT = cnt_q;

    always_comb begin
        SIGNAL = 8'h00;
        if (state_q inside {StDecode, StExec, StMem, StWb}) begin
            case (op)
                OpAdd:   SIGNAL = 8'hC0;
                OpLw:    SIGNAL = 8'h6A;
                OpSw:    SIGNAL = 8'h24;
                default: SIGNAL = 8'h10;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            ir_q      <= 8'h00;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (IR_LOAD) ir_q <= INSTR;
            if (DONE) cnt_q <= cnt_q + CntOne;
            // A new STEP wins over the clear so a request is never lost.
            pending_q <= (pending_q & ~launch_now) | STEP;
            case (state_q)
                StIdle:   if (adv && launch) state_q <= StFetch;
                StFetch:  if (adv) state_q <= StDecode;
                StDecode: if (adv) state_q <= StExec;
                StExec: begin
                    if (adv) begin
                        if (op == OpJ)        state_q <= retire_next;
                        else if (op == OpAdd) state_q <= StWb;
                        else                  state_q <= StMem;
                    end
                end
                StMem:    if (adv) state_q <= (op == OpLw) ? StWb : retire_next;
                StWb:     if (adv) state_q <= retire_next;
                default:  state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus randomized stimulus,
// compared every cycle against a phase-sequence reference model.
module tb_multicycle_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       TICK = 1'b0;
    logic       RUN = 1'b0;
    logic       STEP = 1'b0;
    logic [7:0] INSTR = 8'h00;

    logic       IR_LOAD, PC_INC, PC_JMP, REG_WE, MEM_WE, BUSY, DONE;
    logic [7:0] SIGNAL;
    logic [2:0] PHASE;
    logic [7:0] INSTR_CNT;

    int errors = 0;
    int checks = 0;

    multicycle_sequencer #(.CNT_W(8), .USE_TICK(1'b1)) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .RUN(RUN), .STEP(STEP), .INSTR(INSTR),
        .IR_LOAD(IR_LOAD), .PC_INC(PC_INC), .PC_JMP(PC_JMP), .REG_WE(REG_WE),
        .MEM_WE(MEM_WE), .SIGNAL(SIGNAL), .PHASE(PHASE), .BUSY(BUSY), .DONE(DONE),
        .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: each opcode is a fixed list of phases, FETCH first, retire on the last.
    function automatic int seq_len(input logic [1:0] op);
        case (op)
            2'd0:    return 4;
            2'd1:    return 5;
            2'd2:    return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int phase_at(input logic [1:0] op, input int k);
        if (k < 3) return k + 1;
        if (k == 3) return (op == 2'd0) ? 5 : 4;
        return 5;
    endfunction

    function automatic logic [7:0] sig_of(input logic [1:0] op);
        case (op)
            2'd0:    return 8'hC0;
            2'd1:    return 8'h6A;
            2'd2:    return 8'h24;
            default: return 8'h10;
        endcase
    endfunction

    int         m_phase;
    logic [1:0] m_op;
    logic       m_pend;
    logic [7:0] m_cnt;

    int         n_phase, e_pos;
    logic [1:0] n_op;
    logic       n_pend, e_retire;
    logic [7:0] n_cnt, e_sig;
    logic [25:0] exp_v, obs;

    assign obs = {IR_LOAD, PC_INC, PC_JMP, REG_WE, MEM_WE, SIGNAL, PHASE, BUSY, DONE, INSTR_CNT};

    always_comb begin
        e_pos = -1;
        for (int k = 0; k < 5; k++)
            if (k < seq_len(m_op) && phase_at(m_op, k) == m_phase) e_pos = k;
        e_retire = TICK && (m_phase >= 2) && (e_pos == seq_len(m_op) - 1);
        n_phase = m_phase;
        n_op    = m_op;
        n_pend  = m_pend;
        n_cnt   = m_cnt;
        if (TICK) begin
            if (m_phase == 0) begin
                if (RUN || m_pend) begin n_phase = 1; n_pend = 1'b0; end
            end else if (e_retire) begin
                n_cnt = m_cnt + 8'd1;
                if (RUN || m_pend) begin n_phase = 1; n_pend = 1'b0; end
                else n_phase = 0;
            end else begin
                if (m_phase == 1) n_op = INSTR[7:6];
                n_phase = phase_at(m_op, e_pos + 1);
            end
        end
        if (STEP) n_pend = 1'b1;
        e_sig = (m_phase >= 2) ? sig_of(m_op) : 8'h00;
        exp_v = {TICK && (m_phase == 1), e_retire && (m_op != 2'd3), e_retire && (m_op == 2'd3),
                 e_retire && (m_op <= 2'd1), e_retire && (m_op == 2'd2), e_sig, 3'(m_phase),
                 m_phase != 0, e_retire, m_cnt};
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_phase <= 0;
            m_op    <= 2'd0;
            m_pend  <= 1'b0;
            m_cnt   <= 8'd0;
        end else begin
            m_phase <= n_phase;
            m_op    <= n_op;
            m_pend  <= n_pend;
            m_cnt   <= n_cnt;
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bit found = 0;
        RST = 1'b0; RUN = 1'b0; TICK = 1'b1; STEP = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            checks++;
            if (obs !== 26'h0) begin
                errors++;
                $display("FAIL reset_hold got=%h want=%h", obs, 26'h0);
            end
        end
        next_cycle();
        RST = 1'b1; RUN = 1'b1; INSTR = 8'h40;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_run_model got=%h want=%h", obs, exp_v);
            end
            next_cycle();
            if (PHASE == 3'd4) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_reach_mem got=%0d want=4", PHASE);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (obs !== 26'h0) begin
            errors++;
            $display("FAIL reset_async got=%h want=%h", obs, 26'h0);
        end
        RUN = 1'b0;
        next_cycle();
        next_cycle();
        RST = 1'b1;
    endtask

    task automatic test_step_add();
        int         ph [7] = '{0, 0, 1, 2, 3, 5, 0};
        logic [7:0] sg [7] = '{8'h00, 8'h00, 8'h00, 8'hC0, 8'hC0, 8'hC0, 8'h00};
        RUN = 1'b0; TICK = 1'b1; STEP = 1'b1; INSTR = 8'h1B;
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL add_model c%0d got=%h want=%h", c, obs, exp_v);
            end
            checks++;
            if (PHASE !== 3'(ph[c]) || SIGNAL !== sg[c] || IR_LOAD !== (c == 2)) begin
                errors++;
                $display("FAIL add_phase c%0d got=%0d/%h/%b want=%0d/%h/%b", c, PHASE, SIGNAL,
                         IR_LOAD, ph[c], sg[c], c == 2);
            end
            checks++;
            if ({REG_WE, PC_INC, DONE} !== ((c == 5) ? 3'b111 : 3'b000) ||
                INSTR_CNT !== ((c == 6) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL add_strobes c%0d got=%b cnt=%0d want=%b cnt=%0d", c,
                         {REG_WE, PC_INC, DONE}, INSTR_CNT, (c == 5) ? 3'b111 : 3'b000, c == 6);
            end
            next_cycle();
            STEP = 1'b0;
            if (c >= 2) INSTR = 8'($urandom);
        end
    endtask

    task automatic test_each_op();
        logic [7:0] ops  [3] = '{8'h46, 8'h80, 8'hC1};
        logic [7:0] sigs [3] = '{8'h6A, 8'h24, 8'h10};
        int         nph  [3] = '{5, 4, 3};
        int         nreg [3] = '{1, 0, 0};
        int         nmem [3] = '{0, 1, 0};
        int         ninc [3] = '{1, 1, 0};
        int         njmp [3] = '{0, 0, 1};
        RUN = 1'b0; TICK = 1'b1;
        for (int o = 0; o < 3; o++) begin
            int busy = 0, reg_n = 0, mem_n = 0, inc_n = 0, jmp_n = 0, done_n = 0, sig_bad = 0;
            STEP = 1'b1; INSTR = ops[o];
            for (int i = 0; i < 20 && !(done_n > 0 && PHASE == 3'd0); i++) begin
                @(negedge CLK);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL op%0d_model got=%h want=%h", o, obs, exp_v);
                end
                busy  += int'(BUSY);
                reg_n += int'(REG_WE);
                mem_n += int'(MEM_WE);
                inc_n += int'(PC_INC);
                jmp_n += int'(PC_JMP);
                done_n += int'(DONE);
                if (PHASE >= 3'd2 && SIGNAL !== sigs[o]) sig_bad++;
                next_cycle();
                STEP = 1'b0;
                if (PHASE >= 3'd2) INSTR = 8'($urandom);
            end
            checks++;
            if (busy != nph[o] || done_n != 1 || sig_bad != 0) begin
                errors++;
                $display("FAIL op%0d_len got=%0d/%0d/%0d want=%0d/1/0", o, busy, done_n, sig_bad,
                         nph[o]);
            end
            checks++;
            if (reg_n != nreg[o] || mem_n != nmem[o] || inc_n != ninc[o] || jmp_n != njmp[o]) begin
                errors++;
                $display("FAIL op%0d_strobes got=%0d%0d%0d%0d want=%0d%0d%0d%0d", o, reg_n, mem_n,
                         inc_n, jmp_n, nreg[o], nmem[o], ninc[o], njmp[o]);
            end
        end
    endtask

    task automatic test_run_tick();
        RUN = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            logic [2:0] ph_before;
            logic       tk;
            TICK  = (cyc % 4 == 3);
            INSTR = 8'($urandom);
            @(negedge CLK);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL tick_model cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            ph_before = PHASE;
            tk = TICK;
            next_cycle();
            checks++;
            if (!tk && PHASE !== ph_before) begin
                errors++;
                $display("FAIL tick_gate cyc=%0d got=%0d want=%0d", cyc, PHASE, ph_before);
            end
        end
        RUN = 1'b0; TICK = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL tick_drain got=%h want=%h", obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        bit         wrapped = 0;
        logic [7:0] last = INSTR_CNT;
        RUN = 1'b1; TICK = 1'b1; INSTR = 8'hC1;
        for (int i = 0; i < 1200 && !wrapped; i++) begin
            @(negedge CLK);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL wrap_model got=%h want=%h", obs, exp_v);
            end
            if (last == 8'd255 && INSTR_CNT == 8'd0) wrapped = 1;
            last = INSTR_CNT;
            next_cycle();
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL wrap_seen got=%0d want=wrap 255->0", INSTR_CNT);
        end
        RUN = 1'b0;
        repeat (6) next_cycle();
    endtask

    task automatic test_back_to_back();
        int  done_n = 0;
        bit  found = 0;
        RUN = 1'b0; TICK = 1'b1; INSTR = 8'h00; STEP = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b_model c%0d got=%h want=%h", c, obs, exp_v);
            end
            done_n += int'(DONE);
            next_cycle();
            STEP = (c == 2 || c == 3);
        end
        checks++;
        if (done_n != 2 || PHASE !== 3'd0) begin
            errors++;
            $display("FAIL b2b_count got=%0d ph=%0d want=2 ph=0", done_n, PHASE);
        end
        RUN = 1'b1; done_n = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_cycle();
            if (PHASE == 3'd3) found = 1;
        end
        RUN = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rundrop_model c%0d got=%h want=%h", c, obs, exp_v);
            end
            done_n += int'(DONE);
            next_cycle();
        end
        checks++;
        if (!found || done_n != 1 || PHASE !== 3'd0) begin
            errors++;
            $display("FAIL rundrop_count got=%0d/%b ph=%0d want=1/1 ph=0", done_n, found, PHASE);
        end
    endtask

    task automatic test_reset_mid_sw();
        bit found = 0;
        RUN = 1'b0; TICK = 1'b1; INSTR = 8'h80; STEP = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            next_cycle();
            STEP = 1'b0;
            if (PHASE == 3'd4) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL sw_reach_mem got=%0d want=4", PHASE);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (MEM_WE !== 1'b0 || DONE !== 1'b0 || obs !== 26'h0) begin
            errors++;
            $display("FAIL sw_reset_now got=%h want=%h", obs, 26'h0);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            checks++;
            if (MEM_WE !== 1'b0 || DONE !== 1'b0 || INSTR_CNT !== 8'd0 || obs !== exp_v) begin
                errors++;
                $display("FAIL sw_reset_hold c%0d got=%h want=%h", c, obs, exp_v);
            end
            next_cycle();
            if (c == 3) RST = 1'b1;
        end
    endtask

    task automatic test_random();
        RUN = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            TICK  = 1'($urandom_range(0, 1));
            STEP  = ($urandom % 10 == 0);
            INSTR = 8'($urandom);
            if ($urandom % 16 == 0) RUN = ~RUN;
            @(negedge CLK);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            checks++;
            if ((PC_INC && PC_JMP) || (REG_WE && MEM_WE)) begin
                errors++;
                $display("FAIL rand_exclusive cyc=%0d got=%b%b%b%b want=no overlap", cyc,
                         PC_INC, PC_JMP, REG_WE, MEM_WE);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_step_add();
        test_each_op();
        test_run_tick();
        test_wrap();
        test_back_to_back();
        test_reset_mid_sw();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
